// File: rtl/matmul_pcpi_unit.sv
// PCPI co-processor holding 2x2 matrices A, B (int8) and C (int32): load, multiply, MAC, read-back, clear.
// Simple ops respond 2 cycles after acceptance, MUL/MAC after 9; new instructions are ignored until valid drops after RESP.
module matmul_pcpi_unit #(
  parameter logic [6:0] OPCODE = 7'b0001011
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  output logic        pcpi_ready,
  output logic        pcpi_wr,
  output logic        pcpi_wait,
  output logic [31:0] pcpi_rd
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_EXEC = 3'd1;
  localparam logic [2:0] S_CALC = 3'd2;
  localparam logic [2:0] S_RESP = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  localparam logic [2:0] F_LDA = 3'd0;
  localparam logic [2:0] F_LDB = 3'd1;
  localparam logic [2:0] F_MUL = 3'd2;
  localparam logic [2:0] F_RDC = 3'd3;
  localparam logic [2:0] F_MAC = 3'd4;
  localparam logic [2:0] F_CLR = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [2:0]         step_q, step_d;
  logic [2:0]         f3_q;
  logic [1:0]         idx_q;
  logic [7:0]         imm_q;
  logic signed [7:0]  a_q [4];
  logic signed [7:0]  b_q [4];
  logic signed [31:0] c_q [4];
  logic               ready_q, wr_q, wait_q;
  logic [31:0]        rd_q;

  logic               accept;
  logic [2:0]         in_f3;
  logic [1:0]         e;
  logic               t;
  logic signed [15:0] prod;
  logic signed [31:0] prod_ext;
  logic               unused_insn_bits;

  assign in_f3  = pcpi_insn[14:12];
  assign accept = (state_q == S_IDLE) && pcpi_valid &&
                  (pcpi_insn[6:0] == OPCODE) && (in_f3 <= F_CLR);
  assign unused_insn_bits = ^{pcpi_insn[31:28], pcpi_insn[19:17], pcpi_insn[11:7]};

  // Step k walks C[e] with e = k[2:1]; t selects which of the two inner-product terms.
  assign e        = step_q[2:1];
  assign t        = step_q[0];
  assign prod     = a_q[{e[1], t}] * b_q[{t, e[0]}];
  assign prod_ext = {{16{prod[15]}}, prod};

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (in_f3 == F_MUL || in_f3 == F_MAC) ? S_CALC : S_EXEC;
      S_EXEC: state_d = S_RESP;
      S_CALC: begin
        if (step_q == 3'd7) begin
          state_d = S_RESP;
          step_d  = 3'd0;
        end else begin
          step_d = step_q + 3'd1;
        end
      end
      S_RESP: state_d = S_HOLD;
      S_HOLD: if (!pcpi_valid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      step_q  <= 3'd0;
      f3_q    <= 3'd0;
      idx_q   <= 2'd0;
      imm_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      if (accept) begin
        f3_q  <= in_f3;
        idx_q <= pcpi_insn[16:15];
        imm_q <= pcpi_insn[27:20];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        a_q[i] <= '0;
        b_q[i] <= '0;
        c_q[i] <= '0;
      end
    end else if (state_q == S_EXEC) begin
      case (f3_q)
        F_LDA: a_q[idx_q] <= imm_q;
        F_LDB: b_q[idx_q] <= imm_q;
        F_CLR: begin
          for (int i = 0; i < 4; i++) begin
            a_q[i] <= '0;
            b_q[i] <= '0;
            c_q[i] <= '0;
          end
        end
        default: ;
      endcase
    end else if (state_q == S_CALC) begin
      c_q[e] <= (f3_q == F_MUL && !t) ? prod_ext : c_q[e] + prod_ext;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_q <= 1'b0;
      wr_q    <= 1'b0;
      wait_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      ready_q <= (state_d == S_RESP);
      wait_q  <= (state_d == S_EXEC) || (state_d == S_CALC);
      wr_q    <= (state_d == S_RESP) && (f3_q == F_RDC);
      rd_q    <= ((state_d == S_RESP) && (f3_q == F_RDC)) ? c_q[idx_q] : 32'd0;
    end
  end

  assign pcpi_ready = ready_q;
  assign pcpi_wr    = wr_q;
  assign pcpi_wait  = wait_q;
  assign pcpi_rd    = rd_q;
endmodule

// File: tb/tb_matmul_pcpi_unit.sv
// Randomized bench for matmul_pcpi_unit against a matrix-level reference model.
module tb_matmul_pcpi_unit;
  localparam logic [6:0] OPC = 7'b0001011;
  localparam logic [2:0] F_LDA = 3'd0, F_LDB = 3'd1, F_MUL = 3'd2, F_RDC = 3'd3, F_MAC = 3'd4, F_CLR = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pcpi_valid = 1'b0;
  logic [31:0] pcpi_insn = 32'd0;
  logic        pcpi_ready, pcpi_wr, pcpi_wait;
  logic [31:0] pcpi_rd;

  int tests_run = 0;
  int fails = 0;
  int ma[4], mb[4], mc[4];

  matmul_pcpi_unit #(.OPCODE(OPC)) dut (
    .clk(clk), .rst(rst), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_ready(pcpi_ready), .pcpi_wr(pcpi_wr), .pcpi_wait(pcpi_wait), .pcpi_rd(pcpi_rd)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3,
                                     input logic [1:0] idx, input logic [7:0] imm);
    logic [31:0] w;
    w = $urandom;
    w[6:0] = opc;
    w[14:12] = f3;
    w[16:15] = idx;
    w[27:20] = imm;
    return w;
  endfunction

  // Reference: C = A x B (or C + A x B) as plain integer matrix arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f3, input logic [1:0] idx, input logic [7:0] imm);
    int s;
    model = 32'd0;
    case (f3)
      F_LDA: ma[idx] = int'($signed(imm));
      F_LDB: mb[idx] = int'($signed(imm));
      F_MUL, F_MAC: begin
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++) begin
            s = ma[2*i] * mb[j] + ma[2*i+1] * mb[2+j];
            mc[2*i+j] = (f3 == F_MUL) ? s : mc[2*i+j] + s;
          end
      end
      F_RDC: model = mc[idx];
      F_CLR: for (int i = 0; i < 4; i++) begin ma[i] = 0; mb[i] = 0; mc[i] = 0; end
      default: ;
    endcase
  endfunction

  // Issues one pulsed instruction and observes it through to idle; no checking here.
  task automatic do_op(input logic [2:0] f3, input logic [1:0] idx, input logic [7:0] imm,
                       output int lat, output int waits, output logic [31:0] rdv,
                       output logic wrv, output int stray);
    lat = 0; waits = 0; rdv = 32'd0; wrv = 1'b0; stray = 0;
    pcpi_insn  = mk(OPC, f3, idx, imm);
    pcpi_valid = 1'b1;
    @(posedge clk); #1;
    pcpi_valid = 1'b0;
    for (int k = 0; k < 30; k++) begin
      if (pcpi_ready) begin
        lat = k + 1; rdv = pcpi_rd; wrv = pcpi_wr;
        if (pcpi_wait) stray++;
        break;
      end
      if (pcpi_wait) waits++;
      if (pcpi_wr || pcpi_rd != 32'd0) stray++;
      @(posedge clk); #1;
    end
    repeat (2) begin
      @(posedge clk); #1;
      if (pcpi_ready || pcpi_wr || pcpi_wait || pcpi_rd != 32'd0) stray++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({pcpi_ready, pcpi_wr, pcpi_wait} !== 3'b000) begin
      fails++; $display("FAIL reset_flags: got %b, want 000", {pcpi_ready, pcpi_wr, pcpi_wait});
    end
    tests_run++;
    if (pcpi_rd !== 32'd0) begin fails++; $display("FAIL reset_rd: got %h, want 0", pcpi_rd); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_load_mul();
    int lat, waits, stray; logic [31:0] rdv, exp; logic wrv;
    for (int k = 0; k < 8; k++) begin
      exp = model(k < 4 ? F_LDA : F_LDB, 2'(k), 8'(k + 1));
      do_op(k < 4 ? F_LDA : F_LDB, 2'(k), 8'(k + 1), lat, waits, rdv, wrv, stray);
      tests_run++;
      if (lat != 2 || waits != 1 || wrv !== 1'b0 || stray != 0) begin
        fails++; $display("FAIL load_%0d: lat=%0d waits=%0d wr=%b stray=%0d, want 2/1/0/0", k, lat, waits, wrv, stray);
      end
    end
    exp = model(F_MUL, 2'd0, 8'd0);
    do_op(F_MUL, 2'd0, 8'd0, lat, waits, rdv, wrv, stray);
    tests_run++;
    if (lat != 9 || waits != 8 || stray != 0) begin
      fails++; $display("FAIL mul_timing: lat=%0d waits=%0d stray=%0d, want 9/8/0", lat, waits, stray);
    end
    for (int k = 0; k < 4; k++) begin
      exp = model(F_RDC, 2'(k), 8'd0);
      do_op(F_RDC, 2'(k), 8'd0, lat, waits, rdv, wrv, stray);
      tests_run++;
      if (rdv !== exp || wrv !== 1'b1 || lat != 2 || stray != 0) begin
        fails++; $display("FAIL mul_rdc%0d: rd=%0d wr=%b lat=%0d stray=%0d, want rd=%0d wr=1 lat=2", k, rdv, wrv, lat, stray, exp);
      end
    end
  endtask

  task automatic test_mac();
    int lat, waits, stray; logic [31:0] rdv, exp; logic wrv;
    exp = model(F_MAC, 2'd0, 8'd0);
    do_op(F_MAC, 2'd0, 8'd0, lat, waits, rdv, wrv, stray);
    tests_run++;
    if (lat != 9 || waits != 8) begin fails++; $display("FAIL mac_timing: lat=%0d waits=%0d, want 9/8", lat, waits); end
    for (int k = 0; k < 4; k++) begin
      exp = model(F_RDC, 2'(k), 8'd0);
      do_op(F_RDC, 2'(k), 8'd0, lat, waits, rdv, wrv, stray);
      tests_run++;
      if (rdv !== exp) begin fails++; $display("FAIL mac_rdc%0d: got %0d, want %0d", k, rdv, exp); end
    end
  endtask

  task automatic test_signed();
    int lat, waits, stray; logic [31:0] rdv, exp; logic wrv;
    for (int k = 0; k < 8; k++) begin
      exp = model(k < 4 ? F_LDA : F_LDB, 2'(k), 8'h80);
      do_op(k < 4 ? F_LDA : F_LDB, 2'(k), 8'h80, lat, waits, rdv, wrv, stray);
    end
    exp = model(F_MUL, 2'd0, 8'd0);
    do_op(F_MUL, 2'd0, 8'd0, lat, waits, rdv, wrv, stray);
    for (int k = 0; k < 4; k++) begin
      exp = model(F_RDC, 2'(k), 8'd0);
      do_op(F_RDC, 2'(k), 8'd0, lat, waits, rdv, wrv, stray);
      tests_run++;
      if (rdv !== exp) begin fails++; $display("FAIL signed_rdc%0d: got %h, want %h", k, rdv, exp); end
    end
    exp = model(F_LDA, 2'd0, 8'hFF);
    do_op(F_LDA, 2'd0, 8'hFF, lat, waits, rdv, wrv, stray);
    exp = model(F_LDB, 2'd0, 8'h02);
    do_op(F_LDB, 2'd0, 8'h02, lat, waits, rdv, wrv, stray);
    exp = model(F_MUL, 2'd0, 8'd0);
    do_op(F_MUL, 2'd0, 8'd0, lat, waits, rdv, wrv, stray);
    exp = model(F_RDC, 2'd0, 8'd0);
    do_op(F_RDC, 2'd0, 8'd0, lat, waits, rdv, wrv, stray);
    tests_run++;
    if (rdv !== exp) begin fails++; $display("FAIL signed_mixed: got %h, want %h", rdv, exp); end
  endtask

  task automatic test_random();
    int lat, waits, stray; logic [31:0] rdv, exp; logic wrv; logic [2:0] f3; logic [7:0] v;
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < 8; k++) begin
        v = 8'($urandom);
        exp = model(k < 4 ? F_LDA : F_LDB, 2'(k), v);
        do_op(k < 4 ? F_LDA : F_LDB, 2'(k), v, lat, waits, rdv, wrv, stray);
      end
      f3 = ($urandom_range(1) == 0) ? F_MUL : F_MAC;
      exp = model(f3, 2'd0, 8'd0);
      do_op(f3, 2'd0, 8'd0, lat, waits, rdv, wrv, stray);
      for (int k = 0; k < 4; k++) begin
        exp = model(F_RDC, 2'(k), 8'd0);
        do_op(F_RDC, 2'(k), 8'd0, lat, waits, rdv, wrv, stray);
        tests_run++;
        if (rdv !== exp || stray != 0) begin
          fails++; $display("FAIL random_%0d_rdc%0d: got %h stray=%0d, want %h", it, k, rdv, stray, exp);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, waits, stray, readies; logic [31:0] rdv, exp; logic wrv;
    readies = 0;
    exp = model(F_MAC, 2'd0, 8'd0);
    pcpi_insn  = mk(OPC, F_MAC, 2'd0, 8'd0);
    pcpi_valid = 1'b1;
    repeat (16) begin
      @(posedge clk); #1;
      if (pcpi_ready) readies++;
    end
    pcpi_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (pcpi_ready) readies++;
    end
    tests_run++;
    if (readies != 1) begin fails++; $display("FAIL held_valid_readies: got %0d, want 1", readies); end
    exp = model(F_RDC, 2'd0, 8'd0);
    do_op(F_RDC, 2'd0, 8'd0, lat, waits, rdv, wrv, stray);
    tests_run++;
    if (rdv !== exp || lat != 2) begin fails++; $display("FAIL held_valid_rdc: got %h lat=%0d, want %h lat=2", rdv, lat, exp); end
  endtask

  task automatic test_ignore_in_calc();
    int lat, waits, stray, readies; logic [31:0] rdv, exp; logic wrv;
    readies = 0;
    exp = model(F_MUL, 2'd0, 8'd0);
    pcpi_insn  = mk(OPC, F_MUL, 2'd0, 8'd0);
    pcpi_valid = 1'b1;
    @(posedge clk); #1;
    pcpi_valid = 1'b0;
    @(posedge clk); #1;
    pcpi_insn  = mk(OPC, F_LDA, 2'd0, 8'h55);
    pcpi_valid = 1'b1;
    @(posedge clk); #1;
    pcpi_valid = 1'b0;
    repeat (20) begin
      if (pcpi_ready) readies++;
      @(posedge clk); #1;
    end
    tests_run++;
    if (readies != 1) begin fails++; $display("FAIL calc_ignore_readies: got %0d, want 1", readies); end
    exp = model(F_MUL, 2'd0, 8'd0);
    do_op(F_MUL, 2'd0, 8'd0, lat, waits, rdv, wrv, stray);
    exp = model(F_RDC, 2'd0, 8'd0);
    do_op(F_RDC, 2'd0, 8'd0, lat, waits, rdv, wrv, stray);
    tests_run++;
    if (rdv !== exp) begin fails++; $display("FAIL calc_ignore_a0: got %h, want %h", rdv, exp); end
  endtask

  task automatic test_unrecognized();
    int bad;
    logic [31:0] insns[2];
    insns[0] = mk(7'h33, F_LDA, 2'd0, 8'h11);
    insns[1] = mk(OPC, 3'b110, 2'd0, 8'h11);
    for (int n = 0; n < 2; n++) begin
      bad = 0;
      pcpi_insn  = insns[n];
      pcpi_valid = 1'b1;
      @(posedge clk); #1;
      pcpi_valid = 1'b0;
      repeat (20) begin
        if (pcpi_ready || pcpi_wait || pcpi_wr || pcpi_rd != 32'd0) bad++;
        @(posedge clk); #1;
      end
      tests_run++;
      if (bad != 0) begin fails++; $display("FAIL unrecognized_%0d: active cycles=%0d, want 0", n, bad); end
    end
  endtask

  task automatic test_reset_mid();
    int lat, waits, stray; logic [31:0] rdv, exp; logic wrv;
    pcpi_insn  = mk(OPC, F_MUL, 2'd0, 8'd0);
    pcpi_valid = 1'b1;
    @(posedge clk); #1;
    pcpi_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    tests_run++;
    if ({pcpi_ready, pcpi_wr, pcpi_wait} !== 3'b000 || pcpi_rd !== 32'd0) begin
      fails++; $display("FAIL reset_mid_outputs: flags=%b rd=%h, want 000 and 0", {pcpi_ready, pcpi_wr, pcpi_wait}, pcpi_rd);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin ma[i] = 0; mb[i] = 0; mc[i] = 0; end
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      exp = model(F_RDC, 2'(k), 8'd0);
      do_op(F_RDC, 2'(k), 8'd0, lat, waits, rdv, wrv, stray);
      tests_run++;
      if (rdv !== exp || wrv !== 1'b1) begin fails++; $display("FAIL reset_mid_rdc%0d: got %h wr=%b, want %h wr=1", k, rdv, wrv, exp); end
    end
  endtask

  task automatic test_clr();
    int lat, waits, stray; logic [31:0] rdv, exp; logic wrv; logic [7:0] v;
    for (int k = 0; k < 8; k++) begin
      v = 8'($urandom_range(255, 1));
      exp = model(k < 4 ? F_LDA : F_LDB, 2'(k), v);
      do_op(k < 4 ? F_LDA : F_LDB, 2'(k), v, lat, waits, rdv, wrv, stray);
    end
    exp = model(F_MUL, 2'd0, 8'd0);
    do_op(F_MUL, 2'd0, 8'd0, lat, waits, rdv, wrv, stray);
    exp = model(F_CLR, 2'd0, 8'd0);
    do_op(F_CLR, 2'd0, 8'd0, lat, waits, rdv, wrv, stray);
    tests_run++;
    if (lat != 2) begin fails++; $display("FAIL clr_latency: got %0d, want 2", lat); end
    exp = model(F_MUL, 2'd0, 8'd0);
    do_op(F_MUL, 2'd0, 8'd0, lat, waits, rdv, wrv, stray);
    exp = model(F_RDC, 2'd3, 8'd0);
    do_op(F_RDC, 2'd3, 8'd0, lat, waits, rdv, wrv, stray);
    tests_run++;
    if (rdv !== exp) begin fails++; $display("FAIL clr_rdc3: got %h, want %h", rdv, exp); end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin ma[i] = 0; mb[i] = 0; mc[i] = 0; end
    test_reset();
    test_load_mul();
    test_mac();
    test_signed();
    test_random();
    test_back_to_back();
    test_ignore_in_calc();
    test_unrecognized();
    test_reset_mid();
    test_clr();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule

// File: doc/matmul_pcpi_unit.md
Name: matmul_pcpi_unit

Overview:
- PCPI co-processor sitting directly downstream of the nibble-serial instruction latch: consumes the latched 32-bit custom instruction plus its one-cycle pcpi_valid pulse.
- Holds three 2x2 matrices: A and B with 8-bit signed elements, and C with 32-bit signed elements.
- Executes load, multiply, fused multiply-accumulate, read-back and clear, and signals progress via pcpi_wait/pcpi_ready/pcpi_wr/pcpi_rd.

Parameters:
OPCODE, 7'b0001011, insn[6:0] value the unit responds to (custom-0)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
pcpi_valid  input  1  instruction valid; may be a single-cycle pulse or held
pcpi_insn  input  32  instruction word, sampled only at acceptance
pcpi_ready  output  1  one-cycle completion pulse
pcpi_wr  output  1  high with pcpi_ready when pcpi_rd carries a result
pcpi_wait  output  1  high while an accepted instruction is executing
pcpi_rd  output  32  result data; 0 except in the RESP cycle of RDC

Behaviour:
- Reset: clk and rst only; the reset is asynchronous, active-high. rst=1 at any time, including mid-operation, immediately forces the following. No partial result is preserved.
  - State = IDLE.
  - pcpi_ready = pcpi_wr = pcpi_wait = 0 and pcpi_rd = 0.
  - All A, B and C elements = 0; step counter = 0.
- Instruction fields:
  - [6:0] opcode.
  - [14:12] funct3.
  - [16:15] idx: 0=[0][0], 1=[0][1], 2=[1][0], 3=[1][1].
  - [27:20] imm8.
  - Other bits are ignored.
- funct3 opcodes:
  - 000 LDA: A[idx] <= imm8.
  - 001 LDB: B[idx] <= imm8.
  - 010 MUL: C = A x B.
  - 011 RDC: pcpi_rd = C[idx].
  - 100 MAC: C = C + A x B.
  - 101 CLR: A, B and C all set to 0.
  - 110 and 111 are unrecognized.
- Acceptance:
  - Occurs in IDLE when pcpi_valid=1, opcode==OPCODE and funct3 is recognized; the instruction is captured into an internal register on that edge (cycle N).
  - An unrecognized opcode or funct3 gets no response: it stays IDLE and all outputs remain 0.
  - pcpi_valid outside IDLE is ignored; it does not queue.
- States:
  - IDLE.
  - EXEC: one cycle; performs LDA, LDB, RDC or CLR.
  - CALC: 8 cycles for MUL/MAC.
  - RESP: one cycle.
  - HOLD.
- Transitions:
  - IDLE -> EXEC for LDA, LDB, RDC or CLR.
  - IDLE -> CALC for MUL or MAC.
  - EXEC -> RESP.
  - CALC -> RESP when step==7.
  - RESP -> HOLD.
  - HOLD -> IDLE once pcpi_valid==0. If pcpi_valid is already 0 in RESP, HOLD lasts exactly one cycle. This prevents re-triggering on a held valid.
- Output timing (all outputs registered):
  - pcpi_wait=1 in cycles N+1..ready-1.
  - pcpi_ready=1 only in RESP.
  - Simple ops: ready in cycle N+2.
  - MUL/MAC: ready in cycle N+9; wait is high for 8 cycles.
  - pcpi_wr=1 only in the RESP cycle of RDC; pcpi_rd then = C[idx], and 0 in every other cycle.
- CALC datapath (one signed 8x8 multiply per cycle):
  - step k=0..7, element e=k[2:1], term t=k[0].
  - i=e[1], j=e[0].
  - Product p = A[i][t] * B[t][j], 16-bit signed, sign-extended to 32 bits.
  - MUL: t=0 -> C[e] <= p; t=1 -> C[e] <= C[e] + p.
  - MAC: C[e] <= C[e] + p for both terms.
  - Accumulation is 32-bit two's complement and wraps on overflow; no saturation or flag.
- A and B are read-only during CALC. The step counter returns to 0 on leaving CALC.
- Loads and CLR take effect in EXEC. An RDC after a MUL observes the completed C.

Test Plan:
- Load and multiply: LDA A={1,2,3,4}, LDB B={5,6,7,8}, then MUL.
  - Ready arrives at N+9 with wait high for exactly 8 cycles.
  - RDC idx0..3 returns 19, 22, 43, 50, each with pcpi_wr=1 at N+2.
- Fused accumulate: after the previous test, MAC, then RDC idx0..3 -> 38, 44, 86, 100.
- Signed extremes: all A and all B = 0x80, then MUL.
  - Each C = 0x00008000.
  - With A[0]=0xFF (-1) and B[0]=0x02, the result is C[0] = -2 + (-128*-128) = 0x00003FFE.
- Handshake:
  - Holding pcpi_valid high through RESP gives exactly one ready pulse, with no re-execution until valid drops.
  - A valid pulse during CALC is ignored.
  - Opcode 0x33 or funct3=110 gets no ready and no wait for 20 cycles.
- Reset mid-MUL: assert rst at CALC step 4 -> outputs are 0 immediately, and RDC idx0..3 after release returns 0.
- CLR: after loading, CLR then MUL -> RDC idx3 returns 0.
